// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths, boundary payload structs and occupancy encoding
package pipe_pkg;

  localparam int IF_ID_W = 32;
  localparam int ID_EX_W = 113;
  localparam int EX_ME_W = 81;
  localparam int ME_WB_W = 38;

  typedef struct packed {
    logic [31:0] instr;
  } if_id_t;

  // op is the decoded 4-bit operation class, not the raw RISC-V opcode
  typedef struct packed {
    logic [3:0]  op;
    logic [2:0]  funct3;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] reg1;
    logic [31:0] reg2;
  } id_ex_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [2:0]  funct3;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] alu_result;
    logic [31:0] reg2;
  } ex_me_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic        wb_en;
    logic [31:0] wb_data;
  } me_wb_t;

  localparam logic [1:0] CNT_EMPTY = 2'd0;
  localparam logic [1:0] CNT_ONE   = 2'd1;
  localparam logic [1:0] CNT_FULL  = 2'd2;

  function automatic logic [1:0] occupancy(input logic main_v, input logic skid_v);
    return {1'b0, main_v} + {1'b0, skid_v};
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one register slot (valid, pc, payload) with load/clear controls
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int PAYLOAD_W     = EX_ME_W,
  parameter int PC_W          = 32,
  parameter bit CLEAR_PAYLOAD = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic                 clear_i,
  input  logic [PC_W-1:0]      pc_i,
  input  logic [PAYLOAD_W-1:0] payload_i,
  output logic                 valid_o,
  output logic [PC_W-1:0]      pc_o,
  output logic [PAYLOAD_W-1:0] payload_o
);

  logic                 valid_q, valid_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;

  // Clearing still captures pc_i so an empty slot keeps tracking the incoming PC.
  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    payload_d = payload_q;
    if (clear_i) begin
      valid_d = 1'b0;
      pc_d    = pc_i;
      if (CLEAR_PAYLOAD) payload_d = '0;
    end else if (load_i) begin
      valid_d   = 1'b1;
      pc_d      = pc_i;
      payload_d = payload_i;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      payload_q <= '0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      payload_q <= payload_d;
    end
  end

  assign valid_o   = valid_q;
  assign pc_o      = pc_q;
  assign payload_o = payload_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - elastic pipeline stage: main + skid slot, registered ready, flush
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int PAYLOAD_W       = EX_ME_W,
  parameter int PC_W            = 32,
  parameter bit CLEAR_ON_BUBBLE = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 valid_in,
  output logic                 ready_out,
  input  logic [PC_W-1:0]      pc_in,
  input  logic [PAYLOAD_W-1:0] payload_in,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic [PC_W-1:0]      pc_out,
  output logic [PAYLOAD_W-1:0] payload_out,
  output logic [1:0]           count
);

  logic                 main_v, skid_v;
  logic [PC_W-1:0]      skid_pc;
  logic [PAYLOAD_W-1:0] skid_payload;

  logic                 ready_q;
  logic [1:0]           count_q;

  logic                 in_xfer, out_xfer, main_free;
  logic                 main_load, main_clear, main_from_skid;
  logic                 skid_load, skid_clear;
  logic                 main_v_d, skid_v_d;
  logic [PC_W-1:0]      main_pc_src;
  logic [PAYLOAD_W-1:0] main_payload_src;

  assign in_xfer   = valid_in && ready_q;
  assign out_xfer  = main_v && ready_in;
  assign main_free = !main_v || out_xfer;

  // ready_q mirrors !skid_v, so an input beat never arrives while the skid is draining.
  always_comb begin
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    main_v_d       = main_v;
    skid_v_d       = skid_v;
    if (flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
      main_v_d   = 1'b0;
      skid_v_d   = 1'b0;
    end else if (main_free && skid_v) begin
      main_load      = 1'b1;
      main_from_skid = 1'b1;
      skid_clear     = 1'b1;
      main_v_d       = 1'b1;
      skid_v_d       = 1'b0;
    end else if (main_free) begin
      if (in_xfer) begin
        main_load = 1'b1;
        main_v_d  = 1'b1;
      end else begin
        main_clear = 1'b1;
        main_v_d   = 1'b0;
      end
    end else if (in_xfer) begin
      skid_load = 1'b1;
      skid_v_d  = 1'b1;
    end
  end

  assign main_pc_src      = main_from_skid ? skid_pc : pc_in;
  assign main_payload_src = main_from_skid ? skid_payload : payload_in;

  pipe_slot #(
    .PAYLOAD_W    (PAYLOAD_W),
    .PC_W         (PC_W),
    .CLEAR_PAYLOAD(CLEAR_ON_BUBBLE)
  ) u_main (
    .clock    (clock),
    .reset    (reset),
    .load_i   (main_load),
    .clear_i  (main_clear),
    .pc_i     (main_pc_src),
    .payload_i(main_payload_src),
    .valid_o  (main_v),
    .pc_o     (pc_out),
    .payload_o(payload_out)
  );

  pipe_slot #(
    .PAYLOAD_W    (PAYLOAD_W),
    .PC_W         (PC_W),
    .CLEAR_PAYLOAD(1'b1)
  ) u_skid (
    .clock    (clock),
    .reset    (reset),
    .load_i   (skid_load),
    .clear_i  (skid_clear),
    .pc_i     (pc_in),
    .payload_i(payload_in),
    .valid_o  (skid_v),
    .pc_o     (skid_pc),
    .payload_o(skid_payload)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      ready_q <= 1'b1;
      count_q <= CNT_EMPTY;
    end else begin
      ready_q <= !skid_v_d;
      count_q <= occupancy(main_v_d, skid_v_d);
    end
  end

  assign valid_out = main_v;
  assign ready_out = ready_q;
  assign count     = count_q;

endmodule
